// File: rtl/pkg_cpu.sv
// Shared Cpu/memory-responder types: request size encoding, responder FSM states
// and the request bundle the Cpu's out struct maps onto.
package pkg_cpu;

    typedef enum logic [1:0] {
        SZ_8  = 2'd0,
        SZ_16 = 2'd1,
        SZ_32 = 2'd2,
        SZ_48 = 2'd3
    } ReqDataSz;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_ISSUE,
        RSP_DRAIN,
        RSP_DONE
    } RespState;

    typedef struct packed {
        logic        rd;
        logic        wr;
        ReqDataSz    size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } StrcInMemResponder;

    // Halfword beats needed to move one access of the given size.
    function automatic logic [1:0] beat_count(input ReqDataSz sz);
        case (sz)
            SZ_32:   return 2'd2;
            SZ_48:   return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/cpu_mem_responder.sv
// Services Cpu read/write/fetch requests as halfword beats on a 16-bit sync RAM.
// Read stall N+2 cycles, write N+1, illegal 1; cpu_enable low stalls the Cpu until DONE.
module cpu_mem_responder
    import pkg_cpu::*;
#(
    parameter int MEM_ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  cpu_enable,
    output logic [47:0]           cpu_data_in,
    output logic                  err,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [1:0]            mem_be,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    RespState          state, state_nxt;
    StrcInMemResponder req_in, req_q, beat_src;
    logic [1:0]        bcnt, beat_idx, last_beat, cap_idx;
    logic              cap_vld, req_any, illegal, issue_beat;
    logic [30:0]       hw_addr;
    logic [1:0]        beat_be;
    logic [15:0]       beat_wdata;
    logic              addr_hi_unused;

    assign req_in = '{rd: req_rd, wr: req_wr, size: ReqDataSz'(req_size),
                      addr: req_addr, wdata: req_wdata};
    assign req_any   = req_rd | req_wr;
    assign illegal   = (req_rd & req_wr) | (req_addr[0] & (req_in.size != SZ_8));
    assign last_beat = beat_count(req_q.size) - 2'd1;

    // Only combinational output: the Cpu must stall in the same cycle it asks.
    assign cpu_enable = rst_n & ((state == RSP_IDLE) ? ~req_any : (state == RSP_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RSP_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        issue_beat = 1'b0;
        case (state)
            RSP_IDLE: begin
                if (req_any) begin
                    state_nxt  = illegal ? RSP_DONE : RSP_ISSUE;
                    issue_beat = ~illegal;
                end
            end
            RSP_ISSUE: begin
                if (bcnt == last_beat) state_nxt = req_q.rd ? RSP_DRAIN : RSP_DONE;
                else                   issue_beat = 1'b1;
            end
            RSP_DRAIN: state_nxt = RSP_DONE;
            default:   state_nxt = RSP_IDLE;
        endcase
    end

    // Beat 0 is registered straight from the request so it lands in cycle 1.
    always_comb begin
        beat_src = req_q;
        beat_idx = bcnt + 2'd1;
        if (state == RSP_IDLE) begin
            beat_src = req_in;
            beat_idx = 2'd0;
        end
        hw_addr = beat_src.addr[31:1] + 31'(beat_idx);
        beat_be = 2'b11;
        case (beat_idx)
            2'd0:    beat_wdata = beat_src.wdata[15:0];
            2'd1:    beat_wdata = beat_src.wdata[31:16];
            default: beat_wdata = 16'h0;
        endcase
        if (beat_src.size == SZ_8) begin
            beat_be    = beat_src.addr[0] ? 2'b10 : 2'b01;
            beat_wdata = {2{beat_src.wdata[7:0]}};
        end
        if (beat_src.rd) beat_be = 2'b11;
    end

    assign addr_hi_unused = ^hw_addr[30:MEM_ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            bcnt        <= 2'd0;
            cap_vld     <= 1'b0;
            cap_idx     <= 2'd0;
            cpu_data_in <= '0;
            err         <= 1'b0;
            mem_addr    <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 2'b00;
            mem_wdata   <= 16'h0;
        end else begin
            err     <= (state == RSP_IDLE) & req_any & illegal;
            mem_re  <= issue_beat & beat_src.rd;
            mem_we  <= issue_beat & beat_src.wr;
            cap_vld <= mem_re;
            cap_idx <= bcnt;
            if (issue_beat) begin
                mem_addr  <= hw_addr[MEM_ADDR_W-1:0];
                mem_be    <= beat_be;
                mem_wdata <= beat_src.wr ? beat_wdata : 16'h0;
                bcnt      <= beat_idx;
            end
            if ((state == RSP_IDLE) && req_any) begin
                req_q <= req_in;
                if (illegal || req_rd) cpu_data_in <= '0;
            end else if (cap_vld) begin
                if (req_q.size == SZ_8) begin
                    cpu_data_in <= {40'h0, req_q.addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]};
                end else begin
                    case (cap_idx)
                        2'd0:    cpu_data_in[15:0]  <= mem_rdata;
                        2'd1:    cpu_data_in[31:16] <= mem_rdata;
                        default: cpu_data_in[47:32] <= mem_rdata;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized + directed bench for cpu_mem_responder: byte-level reference memory,
// expectation queue filled by the driver, drained by an independent monitor.
module tb_cpu_mem_responder;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_rd, req_wr;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          cpu_enable;
    logic [47:0]   cpu_data_in;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic          mem_re, mem_we;
    logic [1:0]    mem_be;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;

    always #5 clk = ~clk;

    cpu_mem_responder #(.MEM_ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .cpu_enable (cpu_enable),
        .cpu_data_in(cpu_data_in),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous RAM attached to the DUT.
    logic [15:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_be[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
            if (mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
        end
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Reference: flat byte memory indexed by aliased byte address.
    logic [7:0]  ref_mem [0:131071];
    logic [47:0] ref_last;

    typedef struct {
        int               stalls;
        int               nre;
        int               nwe;
        int               nerr;
        logic [47:0]      data;
        logic [2:0][15:0] addr;
        logic [2:0][1:0]  be;
        logic [2:0][15:0] wd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    int   mon_stall, mon_re, mon_we, mon_err, mon_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic preload(input logic [15:0] hw, input logic [15:0] val);
        ram[hw] = val;
        ref_mem[{hw, 1'b0}] = val[7:0];
        ref_mem[{hw, 1'b1}] = val[15:8];
    endtask

    task automatic model(input bit rd, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int          n;
        logic [15:0] hw, h;
        e.stalls = 0; e.nre = 0; e.nwe = 0; e.nerr = 0;
        e.data = ref_last; e.addr = '0; e.be = '0; e.wd = '0;
        n = (sz == 2'd3) ? 3 : (sz == 2'd2) ? 2 : 1;
        if ((rd && wr) || (a[0] && sz != 2'd0)) begin
            e.stalls = 1; e.nerr = 1; e.data = '0; ref_last = '0;
            return;
        end
        if (rd) begin e.stalls = n + 2; e.nre = n; e.data = '0; end
        else    begin e.stalls = n + 1; e.nwe = n; end
        for (int i = 0; i < n; i++) begin
            hw = 16'((a >> 1) + 32'(i));
            e.addr[i] = hw;
            e.be[i] = 2'b11;
            if (rd) begin
                if (sz == 2'd0) e.data[7:0] = ref_mem[{hw, a[0]}];
                else            e.data[16*i +: 16] = {ref_mem[{hw, 1'b1}], ref_mem[{hw, 1'b0}]};
            end else begin
                h = (i == 0) ? wd[15:0] : (i == 1) ? wd[31:16] : 16'h0;
                if (sz == 2'd0) begin
                    h = {2{wd[7:0]}};
                    e.be[i] = a[0] ? 2'b10 : 2'b01;
                end
                e.wd[i] = h;
                if (e.be[i][0]) ref_mem[{hw, 1'b0}] = h[7:0];
                if (e.be[i][1]) ref_mem[{hw, 1'b1}] = h[15:8];
            end
        end
        if (rd) ref_last = e.data;
    endtask

    // Monitor: checks every memory beat and each completed request.
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            mon_stall = 0; mon_re = 0; mon_we = 0; mon_err = 0; mon_beat = 0;
        end else begin
            if (err) mon_err++;
            if (mem_re || mem_we) begin
                if (exp_q.size() > 0 && mon_beat < 3) begin
                    check("beat_addr", 64'(mem_addr), 64'(exp_q[0].addr[mon_beat]));
                    check("beat_be", 64'(mem_be), 64'(exp_q[0].be[mon_beat]));
                    if (mem_we) check("beat_wdata", 64'(mem_wdata), 64'(exp_q[0].wd[mon_beat]));
                end
                if (mem_re) mon_re++;
                if (mem_we) mon_we++;
                mon_beat++;
            end
            if (req_rd || req_wr) begin
                if (!cpu_enable) mon_stall++;
                else if (exp_q.size() == 0) check("unexpected_done", 64'(exp_q.size()), 64'd1);
                else begin
                    mon_e = exp_q.pop_front();
                    check("stall_cycles", 64'(mon_stall), 64'(mon_e.stalls));
                    check("read_beats", 64'(mon_re), 64'(mon_e.nre));
                    check("write_beats", 64'(mon_we), 64'(mon_e.nwe));
                    check("err_pulses", 64'(mon_err), 64'(mon_e.nerr));
                    check("cpu_data_in", 64'(cpu_data_in), 64'(mon_e.data));
                    mon_stall = 0; mon_re = 0; mon_we = 0; mon_err = 0; mon_beat = 0;
                end
            end
        end
    end

    // Cpu-like driver: holds the request until it sees cpu_enable, then advances.
    task automatic do_req(input bit rd, input bit wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        bit   ok;
        model(rd, wr, sz, a, wd, e);
        exp_q.push_back(e);
        req_rd = rd; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_enable) begin ok = 1'b1; break; end
        end
        check("done_within_budget", 64'(ok), 64'd1);
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_rd = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
        ref_last = '0;
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
        for (int i = 0; i < 131072; i++) ref_mem[i] = 8'h0;
        preload(16'h0008, 16'hBEEF);
        preload(16'h0010, 16'h1111);
        preload(16'h0011, 16'h2222);
        preload(16'h0012, 16'h3333);

        repeat (3) @(posedge clk);
        #1 check("rst_cpu_enable_low", 64'(cpu_enable), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("rst_cpu_data_in", 64'(cpu_data_in), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_mem_re", 64'(mem_re), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_be", 64'(mem_be), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("idle_cpu_enable", 64'(cpu_enable), 64'd1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        do_req(1, 0, 2'd1, 32'h0000_0010, 32'h0);           // halfword read -> BEEF
        do_req(1, 0, 2'd3, 32'h0000_0020, 32'h0);           // 48-bit fetch
        do_req(0, 1, 2'd0, 32'h0000_0031, 32'h0000_00A5);   // byte write, upper lane
        do_req(1, 0, 2'd0, 32'h0000_0031, 32'h0);           // byte read back
        do_req(1, 0, 2'd2, 32'h0000_0041, 32'h0);           // misaligned -> illegal
        do_req(1, 1, 2'd1, 32'h0000_0050, 32'h0);           // rd & wr -> illegal
        do_req(0, 1, 2'd2, 32'hFFFF_FFFE, 32'hDEAD_BEEF);   // wrapping write
        do_req(1, 0, 2'd2, 32'hFFFF_FFFE, 32'h0);           // wrapping read

        for (int t = 0; t < 200; t++) begin
            int          r, gap;
            bit          rd, wr;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            r   = $urandom_range(0, 19);
            rd  = (r < 10);
            wr  = (r == 0) || (r >= 10);
            sz  = 2'($urandom_range(0, 3));
            a   = ($urandom() & 32'hFFFE_0000) | 32'($urandom_range(0, 95));
            if (sz != 2'd0 && $urandom_range(0, 7) != 0) a[0] = 1'b0;
            wd  = $urandom();
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            do_req(rd, wr, sz, a, wd);
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
        end

        // Reset in the middle of a 32-bit write: only beat 0 reaches memory.
        mon_en = 1'b0;
        req_wr = 1'b1; req_size = 2'd2; req_addr = 32'h0000_0100; req_wdata = 32'h1234_5678;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (mem_we && mem_addr == 16'h0081) begin seen = 1'b1; break; end
            end
            check("second_write_beat_seen", 64'(seen), 64'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_we", 64'(mem_we), 64'd0);
        check("abort_cpu_enable", 64'(cpu_enable), 64'd0);
        check("abort_mem_addr", 64'(mem_addr), 64'd0);
        check("abort_cpu_data_in", 64'(cpu_data_in), 64'd0);
        req_wr = 1'b0;
        ref_mem[17'h100] = 8'h78;
        ref_mem[17'h101] = 8'h56;
        ref_last = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        do_req(1, 0, 2'd2, 32'h0000_0100, 32'h0);

        repeat (3) @(posedge clk);
        check("expectations_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
